// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter: FSM state encoding,
// default sizing and the round-robin pointer advance.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int N_REQ_DFLT = 4;
  localparam int DEPTH_DFLT = 16;
  localparam int IDW        = $clog2(N_REQ_DFLT);
  localparam int OCCW       = $clog2(DEPTH_DFLT + 1);

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request at or above
// ptr_i (wrapping) wins and is reported one-hot and as a binary index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IDX_W-1:0] win_id_o,
  output logic             any_o
);

  always_comb begin
    win_o    = '0;
    win_id_o = '0;
    any_o    = |req_i;
    // Scan farthest-first so the candidate closest to ptr_i overwrites the rest.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr_i) + k) % N_REQ;
      if (req_i[j]) begin
        win_o    = '0;
        win_o[j] = 1'b1;
        win_id_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ valid/ready
// producers, with burst-limited grants and a local occupancy credit counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DFLT,
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DFLT,
  parameter int BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_wr_data,
  input  logic                       fifo_rd_pop,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = $clog2(BURST + 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   gid_q, gid_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               wr_en_q;
  logic [WIDTH-1:0]   wr_data_q;

  logic [N_REQ-1:0]   pick_win;
  logic [IDX_W-1:0]   pick_id;
  logic               pick_any;
  logic               room;
  logic               owner_valid;
  logic               accept;
  logic               pop_eff;
  logic [BEAT_W-1:0]  beat_inc;
  logic [WIDTH-1:0]   owner_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_q),
    .win_o    (pick_win),
    .win_id_o (pick_id),
    .any_o    (pick_any)
  );

  // Credits count accepted words, so room is known without waiting on FIFO flags.
  assign room        = occ_q < OCC_W'(DEPTH);
  assign req_ready   = (state_q == GRANT && room) ? grant_q : '0;
  assign owner_valid = |(req_valid & grant_q);
  assign accept      = |(req_valid & req_ready);
  assign pop_eff     = fifo_rd_pop && (occ_q != '0);
  assign beat_inc    = beat_q + BEAT_W'(1);

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gid_q == IDX_W'(i)) owner_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_any && room) begin
          state_d = GRANT;
          grant_d = pick_win;
          gid_d   = pick_id;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (!owner_valid || (accept && beat_inc == BEAT_W'(BURST))) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = IDX_W'(rr_next(int'(gid_q), N_REQ));
          beat_d  = accept ? beat_inc : beat_q;
        end else if (accept) begin
          beat_d = beat_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({accept, pop_eff})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gid_q     <= '0;
      rr_q      <= '0;
      beat_q    <= '0;
      occ_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      occ_q   <= occ_d;
      wr_en_q <= accept;
      if (accept) wr_data_q <= owner_data;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign grant        = grant_q;
  assign grant_id     = gid_q;
  assign occupancy    = occ_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter: reset, bursts, round-robin order,
// fill/back-pressure, credit arithmetic and early release.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 16;
  localparam int B = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_wr_en;
  logic [W-1:0]    fifo_wr_data;
  logic            fifo_rd_pop;
  logic [N-1:0]    grant;
  logic [IDW-1:0]  grant_id;
  logic [OCCW-1:0] occupancy;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D), .BURST(B)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_pop  (fifo_rd_pop),
    .grant        (grant),
    .grant_id     (grant_id),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  int         acc_cnt  [N];
  int         word_cnt [N];
  logic [W-1:0] base   [N];
  logic [W-1:0] wr_log [$];
  int         grant_log [$];
  int         beats_log [$];
  int         cur_beats;
  int         occ_max;
  logic [N-1:0] prev_grant;

  task automatic set_base(input int i, input logic [W-1:0] b);
    base[i] = b;
    req_data[i*W +: W] = b + W'(word_cnt[i]);
  endtask

  // One clock: record handshakes, advance producer words, log writes and grants.
  task automatic cycle();
    logic [N-1:0] hs;
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        acc_cnt[i]++;
        word_cnt[i]++;
        req_data[i*W +: W] = base[i] + W'(word_cnt[i]);
      end
    end
    cur_beats += $countones(hs);
    if (fifo_wr_en) wr_log.push_back(fifo_wr_data);
    if (grant != '0 && prev_grant == '0) grant_log.push_back(int'(grant_id));
    if (grant == '0 && prev_grant != '0) begin
      beats_log.push_back(cur_beats);
      cur_beats = 0;
    end
    prev_grant = grant;
    if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    req_valid   = '0;
    fifo_rd_pop = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc_cnt[i]  = 0;
      word_cnt[i] = 0;
      set_base(i, W'(i * 16));
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_log.delete();
    grant_log.delete();
    beats_log.delete();
    cur_beats  = 0;
    occ_max    = 0;
    prev_grant = '0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (grant !== 4'b0000) begin tests_failed++; $display("FAIL rst_grant got %b want 0000", grant); end
    tests_run++;
    if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL rst_grant_id got %0d want 0", grant_id); end
    tests_run++;
    if (occupancy !== 5'd0) begin tests_failed++; $display("FAIL rst_occ got %0d want 0", occupancy); end
    tests_run++;
    if (fifo_wr_en !== 1'b0) begin tests_failed++; $display("FAIL rst_wr_en got %b want 0", fifo_wr_en); end
    tests_run++;
    if (fifo_wr_data !== 8'h00) begin tests_failed++; $display("FAIL rst_wr_data got %h want 00", fifo_wr_data); end
    tests_run++;
    if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rst_ready got %b want 0000", req_ready); end

    // Build up a burst mid-flight: grant=0010 with two beats taken.
    req_valid = 4'b0010;
    repeat (3) cycle();
    tests_run++;
    if (grant !== 4'b0010 || acc_cnt[1] != 2) begin
      tests_failed++; $display("FAIL rst_pre grant %b beats %0d want 0010 beats 2", grant, acc_cnt[1]);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (grant !== 4'b0000 || occupancy !== 5'd0 || fifo_wr_en !== 1'b0) begin
      tests_failed++; $display("FAIL rst_async grant %b occ %0d wr_en %b want 0000 0 0", grant, occupancy, fifo_wr_en);
    end
    req_valid = '0;
    #3;
    rst_n = 1'b1;
    wr_log.delete();
    prev_grant = '0;
    repeat (3) cycle();
    tests_run++;
    if (wr_log.size() != 0) begin tests_failed++; $display("FAIL rst_no_write got %0d writes want 0", wr_log.size()); end
    tests_run++;
    if (occupancy !== 5'd0) begin tests_failed++; $display("FAIL rst_occ_after got %0d want 0", occupancy); end
  endtask

  task automatic test_single_burst();
    logic [N-1:0] exp_g [9];
    logic         exp_w [9];
    logic [N-1:0] g_hist [9];
    logic         w_hist [9];
    exp_g = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
    exp_w = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    set_base(2, 8'hA0);
    req_valid = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      cycle();
      g_hist[c] = grant;
      w_hist[c] = fifo_wr_en;
      if (acc_cnt[2] == 6) req_valid[2] = 1'b0;
    end
    for (int c = 0; c < 9; c++) begin
      tests_run++;
      if (g_hist[c] !== exp_g[c] || w_hist[c] !== exp_w[c]) begin
        tests_failed++;
        $display("FAIL single_c%0d grant %b wr_en %b want %b %b", c + 1, g_hist[c], w_hist[c], exp_g[c], exp_w[c]);
      end
    end
    tests_run++;
    if (wr_log.size() != 6) begin tests_failed++; $display("FAIL single_count got %0d want 6", wr_log.size()); end
    for (int k = 0; k < 6 && k < wr_log.size(); k++) begin
      tests_run++;
      if (wr_log[k] !== 8'hA0 + 8'(k)) begin
        tests_failed++; $display("FAIL single_data%0d got %h want %h", k, wr_log[k], 8'hA0 + 8'(k));
      end
    end
    tests_run++;
    if (beats_log.size() != 2 || beats_log[0] != 4 || beats_log[1] != 2) begin
      tests_failed++; $display("FAIL single_beats got n=%0d want 4,2", beats_log.size());
    end
    tests_run++;
    if (occupancy !== 5'd6) begin tests_failed++; $display("FAIL single_occ got %0d want 6", occupancy); end
  endtask

  task automatic test_round_robin();
    int exp_id [5];
    exp_id = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid   = 4'b1111;
    fifo_rd_pop = 1'b1;
    repeat (30) cycle();
    req_valid   = '0;
    fifo_rd_pop = 1'b0;
    tests_run++;
    if (grant_log.size() < 5) begin
      tests_failed++; $display("FAIL rr_grants got %0d want >=5", grant_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests_run++;
        if (grant_log[k] != exp_id[k]) begin
          tests_failed++; $display("FAIL rr_id%0d got %0d want %0d", k, grant_log[k], exp_id[k]);
        end
      end
    end
    for (int k = 0; k < 5 && k < beats_log.size(); k++) begin
      tests_run++;
      if (beats_log[k] != B) begin tests_failed++; $display("FAIL rr_beats%0d got %0d want %0d", k, beats_log[k], B); end
    end
    tests_run++;
    if (occ_max != 1) begin tests_failed++; $display("FAIL rr_occ_max got %0d want 1", occ_max); end
    tests_run++;
    if (wr_log.size() < 5 || wr_log[3] !== 8'h03 || wr_log[4] !== 8'h10) begin
      tests_failed++; $display("FAIL rr_order got n=%0d want 03 then 10 at 3,4", wr_log.size());
    end
  endtask

  task automatic test_fill();
    do_reset();
    req_valid = 4'b0001;
    for (int k = 0; k < 10 && acc_cnt[0] < 1; k++) cycle();
    req_valid = '0;
    for (int k = 0; k < 5 && grant != '0; k++) cycle();
    req_valid = 4'b0001;
    for (int k = 0; k < 60 && acc_cnt[0] < 16; k++) cycle();
    repeat (3) cycle();
    tests_run++;
    if (acc_cnt[0] != 16) begin tests_failed++; $display("FAIL fill_beats got %0d want 16", acc_cnt[0]); end
    tests_run++;
    if (occupancy !== 5'd16) begin tests_failed++; $display("FAIL fill_occ got %0d want 16", occupancy); end
    tests_run++;
    if (req_ready !== 4'b0000 || grant !== 4'b0001) begin
      tests_failed++; $display("FAIL fill_hold ready %b grant %b want 0000 0001", req_ready, grant);
    end
    tests_run++;
    if (wr_log.size() != 16 || wr_log[15] !== 8'h0F) begin
      tests_failed++; $display("FAIL fill_log got n=%0d want 16 ending 0f", wr_log.size());
    end
    fifo_rd_pop = 1'b1;
    cycle();
    fifo_rd_pop = 1'b0;
    repeat (4) cycle();
    tests_run++;
    if (acc_cnt[0] != 17) begin tests_failed++; $display("FAIL fill_one_more got %0d want 17", acc_cnt[0]); end
    tests_run++;
    if (occupancy !== 5'd16 || grant !== 4'b0000) begin
      tests_failed++; $display("FAIL fill_after occ %0d grant %b want 16 0000", occupancy, grant);
    end
  endtask

  task automatic test_simul_pop();
    do_reset();
    req_valid = 4'b1000;
    for (int k = 0; k < 40 && acc_cnt[3] < 10; k++) cycle();
    tests_run++;
    if (occupancy !== 5'd10 || req_ready !== 4'b1000) begin
      tests_failed++; $display("FAIL simul_pre occ %0d ready %b want 10 1000", occupancy, req_ready);
    end
    fifo_rd_pop = 1'b1;
    cycle();
    fifo_rd_pop = 1'b0;
    req_valid   = '0;
    tests_run++;
    if (occupancy !== 5'd10 || acc_cnt[3] != 11) begin
      tests_failed++; $display("FAIL simul_occ occ %0d beats %0d want 10 11", occupancy, acc_cnt[3]);
    end
    fifo_rd_pop = 1'b1;
    cycle();
    fifo_rd_pop = 1'b0;
    tests_run++;
    if (occupancy !== 5'd9) begin tests_failed++; $display("FAIL pop_only got %0d want 9", occupancy); end
  endtask

  task automatic test_pop_empty();
    do_reset();
    fifo_rd_pop = 1'b1;
    repeat (3) cycle();
    fifo_rd_pop = 1'b0;
    tests_run++;
    if (occupancy !== 5'd0) begin tests_failed++; $display("FAIL pop_empty got %0d want 0", occupancy); end
  endtask

  task automatic test_release();
    do_reset();
    req_valid = 4'b0010;
    for (int k = 0; k < 10 && acc_cnt[1] < 1; k++) cycle();
    req_valid = '0;
    tests_run++;
    if (grant !== 4'b0010) begin tests_failed++; $display("FAIL rel_owner got %b want 0010", grant); end
    cycle();
    tests_run++;
    if (grant !== 4'b0000 || grant_id !== 2'd1) begin
      tests_failed++; $display("FAIL rel_drop grant %b id %0d want 0000 1", grant, grant_id);
    end
    req_valid = 4'b0101;
    cycle();
    tests_run++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      tests_failed++; $display("FAIL rel_next grant %b id %0d want 0100 2", grant, grant_id);
    end
    req_valid = '0;
    repeat (2) cycle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    fifo_rd_pop  = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_fill();
    test_simul_pop();
    test_pop_empty();
    test_release();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
